// File: rtl/magnetron_sequencer_if.sv
// Front-end/drive bundle for the magnetron sequencer: button levels, door, tick and load in; drive and status out.
interface magnetron_sequencer_if #(
    parameter int TIME_W = 12
);
    logic              startn;
    logic              stopn;
    logic              clearn;
    logic              door_closed;
    logic              tick;
    logic              load_en;
    logic [TIME_W-1:0] load_time;
    logic [3:0]        load_power;
    logic              mag_on;
    logic [TIME_W-1:0] remaining;
    logic [1:0]        state;
    logic              done_pulse;
    logic              beep;

    modport master (
        output startn, stopn, clearn, door_closed, tick, load_en, load_time, load_power,
        input  mag_on, remaining, state, done_pulse, beep
    );

    modport slave (
        input  startn, stopn, clearn, door_closed, tick, load_en, load_time, load_power,
        output mag_on, remaining, state, done_pulse, beep
    );
endinterface

// File: rtl/magnetron_sequencer.sv
// Cook-cycle controller: counts cook time down on a 1 Hz tick, duty-cycles mag_on by power level,
// handles pause/resume/clear/door interlock and beeps on completion. Buttons act one edge after being sampled.
module magnetron_sequencer #(
    parameter int TIME_W     = 12,
    parameter int BEEP_TICKS = 3
) (
    input  logic                    clk,
    input  logic                    resetn,
    magnetron_sequencer_if.slave    bus
);
    localparam int BW = (BEEP_TICKS < 1) ? 1 : $clog2(BEEP_TICKS + 1);
    localparam logic [BW-1:0] BEEP_MAX = BW'(BEEP_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [TIME_W-1:0] remaining_q, remaining_d;
    logic [3:0]        power_q, power_d;
    logic [3:0]        phase_q, phase_d;
    logic [BW-1:0]     beep_cnt_q, beep_cnt_d;
    logic              done_pulse_q, done_pulse_d;

    // Buttons are sampled once, then compared against the previous sample for a falling edge.
    logic start_s_q, stop_s_q, clear_s_q;
    logic start_prev_q, stop_prev_q, clear_prev_q;

    logic start_ev, stop_ev, clear_ev;
    logic [3:0] load_power_sat;

    assign start_ev = start_prev_q & ~start_s_q;
    assign stop_ev  = stop_prev_q  & ~stop_s_q;
    assign clear_ev = clear_prev_q & ~clear_s_q;

    assign load_power_sat = (bus.load_power == 4'd0 || bus.load_power > 4'd10) ? 4'd10 : bus.load_power;

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        power_d      = power_q;
        phase_d      = phase_q;
        beep_cnt_d   = beep_cnt_q;
        done_pulse_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clear_ev) begin
                    remaining_d = '0;
                end else begin
                    if (bus.load_en) begin
                        remaining_d = bus.load_time;
                        power_d     = load_power_sat;
                    end
                    if (start_ev && bus.door_closed && remaining_q != '0) begin
                        state_d = ST_COOK;
                        phase_d = 4'd0;
                    end
                end
            end
            ST_COOK: begin
                if (clear_ev) begin
                    state_d     = ST_IDLE;
                    remaining_d = '0;
                end else if (!bus.door_closed || stop_ev) begin
                    state_d = ST_PAUSE;
                end else if (bus.tick && !start_ev) begin
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - 1'b1;
                    end
                    phase_d = (phase_q == 4'd9) ? 4'd0 : phase_q + 4'd1;
                    if (remaining_q == TIME_W'(1)) begin
                        state_d      = ST_DONE;
                        done_pulse_d = 1'b1;
                        beep_cnt_d   = '0;
                    end
                end
            end
            ST_PAUSE: begin
                if (clear_ev || stop_ev) begin
                    state_d     = ST_IDLE;
                    remaining_d = '0;
                end else if (start_ev && bus.door_closed) begin
                    state_d = ST_COOK;
                    phase_d = 4'd0;
                end
            end
            ST_DONE: begin
                if (start_ev || stop_ev || clear_ev || !bus.door_closed || bus.load_en) begin
                    state_d = ST_IDLE;
                    if (bus.load_en) begin
                        remaining_d = bus.load_time;
                        power_d     = load_power_sat;
                    end
                end else if (beep_cnt_q >= BEEP_MAX) begin
                    state_d = ST_IDLE;
                end else if (bus.tick) begin
                    beep_cnt_d = beep_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            power_q      <= 4'd10;
            phase_q      <= 4'd0;
            beep_cnt_q   <= '0;
            done_pulse_q <= 1'b0;
            start_s_q    <= 1'b1;
            stop_s_q     <= 1'b1;
            clear_s_q    <= 1'b1;
            start_prev_q <= 1'b1;
            stop_prev_q  <= 1'b1;
            clear_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            power_q      <= power_d;
            phase_q      <= phase_d;
            beep_cnt_q   <= beep_cnt_d;
            done_pulse_q <= done_pulse_d;
            start_s_q    <= bus.startn;
            stop_s_q     <= bus.stopn;
            clear_s_q    <= bus.clearn;
            start_prev_q <= start_s_q;
            stop_prev_q  <= stop_s_q;
            clear_prev_q <= clear_s_q;
        end
    end

    // Door term is raw so opening the door kills the magnetron without waiting for a clock edge.
    assign bus.mag_on     = (state_q == ST_COOK) & bus.door_closed & (phase_q < power_q);
    assign bus.remaining  = remaining_q;
    assign bus.state      = state_q;
    assign bus.done_pulse = done_pulse_q;
    assign bus.beep       = (state_q == ST_DONE) & (beep_cnt_q < BEEP_MAX);
endmodule
